uart_word_packer: RTL and testbench
===================================

Name: uart_word_packer

Overview:
- Parametrised successor of the cycle UART input block: receives async serial characters, packs WORD_PART-bit characters into WORD_SIZE-bit words, and queues them in a MEM_SIZE-deep word FIFO.
- Adds a configurable bit timing, optional parity, error detection, and delimiter-driven word break: a delimiter character flushes a partial word.
- Sits between the UART pin and the word-join/processing logic, which pops words with read_req.

Parameters:
- WORD_SIZE, 32, output word width; must be a multiple of WORD_PART.
- WORD_PART, 8, data bits per serial frame (5..8); NPARTS = WORD_SIZE/WORD_PART.
- MEM_SIZE, 64, FIFO depth in words; power of two, >= 2.
- CLKS_PER_BIT, 868, clock cycles per serial bit (100 MHz / 115200 baud).
- PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd.
- DELIM, 9, delimiter character value (tab); must be < 2^WORD_PART.

Ports:
- clock, in, 1, single system clock; all logic on the rising edge.
- reset, in, 1, synchronous, active-low reset.
- sig, in, 1, async serial line; idle high.
- read_req, in, 1, one-cycle pop request.
- clear_err, in, 1, one-cycle clear of sticky error flags.
- data_out, out, WORD_SIZE, word at the FIFO head after a pop.
- parts, out, clog2(NPARTS+1), number of valid characters in data_out.
- full, out, 1, FIFO holds MEM_SIZE words.
- empty, out, 1, FIFO holds 0 words.
- frame_err, out, 1, sticky: a stop bit was sampled low.
- parity_err, out, 1, sticky: a parity mismatch occurred.
- overflow, out, 1, sticky: a word was dropped because the FIFO was full.

Behaviour:
- Reset (reset=0 at a clock edge):
  - data_out=0, parts=0, full=0, empty=1, all error flags 0.
  - FSM goes to IDLE, packer index k=0, FIFO pointers and count = 0.
  - A frame or partial word in progress is discarded.
- Input synchronisation: sig passes through a 2-FF synchroniser. All references to sig below mean the synchronised value.
- RX FSM:
  - IDLE: on a falling edge of sig, go to START with the bit counter cleared.
  - START: wait CLKS_PER_BIT/2 cycles, then sample. If low, go to DATA. If high, treat as a glitch and return to IDLE.
  - DATA: sample every CLKS_PER_BIT cycles, WORD_PART bits, LSB first. Then go to PARITY if PARITY_MODE != 0, else STOP.
  - PARITY: sample one bit and compare against the even/odd parity of the data bits.
  - STOP: sample one bit.
    - Stop high and parity ok: the character is accepted, with a one-cycle internal strobe on the cycle after the stop sample.
    - Stop low: set frame_err and discard the character. Go to WAIT_HIGH, which returns to IDLE once sig is high.
    - Parity bad: set parity_err, discard the character, return to IDLE.
- Packer, on an accepted character c:
  - c == DELIM and k > 0: push word {zeros, parts 0..k-1} with parts=k, then k=0.
  - c == DELIM and k == 0: no push; empty words are never produced. The delimiter itself is never stored.
  - Otherwise: write c to bits [k*WORD_PART +: WORD_PART] (first character in the LSBs), k++. If k reaches NPARTS, push with parts=NPARTS and k=0.
  - Unwritten bits of a pushed word are 0. The word register is cleared after each push.
- FIFO:
  - A push occurs in the cycle after the accept strobe.
  - Push while full (with no pop in the same cycle): the word is dropped, overflow is set, and the packer state is still cleared.
  - Pop: read_req=1 and empty=0. data_out/parts update on the next edge and hold until the next pop.
  - read_req while empty is ignored; outputs hold.
  - Simultaneous push and pop is legal in any state, including full: count is unchanged, and both operations take effect.
  - full and empty are registered from the count and reflect the post-edge state. Pointers wrap modulo MEM_SIZE.
- Error flags: clear_err clears all sticky flags. If a flag sets in the same cycle as clear_err, set wins.
- Latency: stop-bit mid-sample -> accept strobe +1 -> FIFO write +1 -> empty deasserts on that same edge.

Test Plan:
- 8N1, CLKS_PER_BIT=868, send "hello\tworld\t" (0x68 65 6C 6C 6F 09 77 6F 72 6C 64 09), then pop 4 times. Required pops, in order:
  - 0x6C6C6568 with parts=4
  - 0x0000006F with parts=1
  - 0x6C726F77 with parts=4
  - 0x00000064 with parts=1
  - Afterwards empty=1 and no error flags are set.
- Send "\t\tab\t" -> exactly one word, 0x00006261 with parts=2. Leading delimiters produce nothing.
- Frame with the stop bit driven low, then 'A' -> frame_err=1, only 'A' is packed (k=1), no push. clear_err -> frame_err=0.
- PARITY_MODE=1, send 0x03 with parity bit 1 -> parity_err=1 and the character is dropped. Send 0x03 with parity 0 -> accepted.
- MEM_SIZE=4, send 20 non-delimiter characters, no pops:
  - full=1 after 16 characters; the 5th word is dropped and overflow=1.
  - First pop returns the 1st word. Then a push and pop in the same cycle at full leaves full=1.
- Edge cases:
  - A 300-cycle low glitch on sig produces no character.
  - Asserting reset mid-DATA gives empty=1 and k=0.
  - After reset, a clean "ab\t" yields 0x00006261.

Source files
------------

// File: rtl/uart_word_packer.sv
`timescale 1ns/1ps
// uart_word_packer
//
// Receives asynchronous serial characters, packs WORD_PART-bit characters
// into WORD_SIZE-bit words (first character in the LSBs) and queues the
// words in a MEM_SIZE-deep FIFO. A DELIM character flushes a partial word;
// the delimiter itself is never stored and empty words are never produced.
//
// Ports:
//   clock      - system clock, all logic on the rising edge
//   reset      - synchronous, active-low reset
//   sig        - asynchronous serial line, idle high
//   read_req   - one-cycle pop request (ignored while empty)
//   clear_err  - one-cycle clear of the sticky error flags
//   data_out   - word popped from the FIFO head, held until the next pop
//   parts      - number of valid characters in data_out
//   full       - FIFO holds MEM_SIZE words
//   empty      - FIFO holds no words
//   frame_err  - sticky: a stop bit was sampled low
//   parity_err - sticky: a parity mismatch occurred
//   overflow   - sticky: a word was dropped because the FIFO was full
module uart_word_packer #(
    parameter int WORD_SIZE    = 32,
    parameter int WORD_PART    = 8,
    parameter int MEM_SIZE     = 64,
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY_MODE  = 0,
    parameter int DELIM        = 9
) (
    input  logic                                          clock,
    input  logic                                          reset,
    input  logic                                          sig,
    input  logic                                          read_req,
    input  logic                                          clear_err,
    output logic [WORD_SIZE-1:0]                          data_out,
    output logic [$clog2(WORD_SIZE/WORD_PART+1)-1:0]      parts,
    output logic                                          full,
    output logic                                          empty,
    output logic                                          frame_err,
    output logic                                          parity_err,
    output logic                                          overflow
);

    localparam int NPARTS = WORD_SIZE / WORD_PART;
    localparam int PW     = $clog2(NPARTS + 1);
    localparam int AW     = $clog2(MEM_SIZE);
    localparam int CW     = $clog2(MEM_SIZE + 1);
    localparam int CNTW   = $clog2(CLKS_PER_BIT);
    localparam int BW     = $clog2(WORD_PART);

    localparam logic [CNTW-1:0]      BIT_LAST  = CNTW'(CLKS_PER_BIT - 1);
    localparam logic [CNTW-1:0]      HALF_LAST = CNTW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0]        LAST_BIT  = BW'(WORD_PART - 1);
    localparam logic [PW-1:0]        LAST_PART = PW'(NPARTS - 1);
    localparam logic [PW-1:0]        ALL_PARTS = PW'(NPARTS);
    localparam logic [WORD_PART-1:0] DELIM_C   = WORD_PART'(DELIM);
    localparam logic [CW-1:0]        MEM_FULL  = CW'(MEM_SIZE);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_HIGH
    } rx_state_e;

    // Synchroniser and edge detect
    logic sync1_q, sync2_q, prev_q;

    // Receiver
    rx_state_e             state_q, state_d;
    logic [CNTW-1:0]       cnt_q, cnt_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [WORD_PART-1:0]  shift_q, shift_d;
    logic                  par_bad_q, par_bad_d;
    logic                  accept_q, accept_d;
    logic                  set_frame, set_parity;
    logic                  exp_parity;

    // Packer
    logic [PW-1:0]         k_q, k_d;
    logic [WORD_SIZE-1:0]  word_q, word_d, merged;
    logic                  push_q, push_d;
    logic [WORD_SIZE-1:0]  push_word_q, push_word_d;
    logic [PW-1:0]         push_parts_q, push_parts_d;

    // FIFO
    logic [WORD_SIZE-1:0]  mem_q [MEM_SIZE];
    logic [PW-1:0]         mem_parts_q [MEM_SIZE];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  do_pop, do_write, push_blocked;
    logic [WORD_SIZE-1:0]  data_out_q, data_out_d;
    logic [PW-1:0]         parts_q, parts_d;
    logic                  full_q, full_d, empty_q, empty_d;
    logic                  frame_err_q, frame_err_d;
    logic                  parity_err_q, parity_err_d;
    logic                  overflow_q, overflow_d;

    // Expected parity bit: even mode makes the total count of ones even.
    assign exp_parity = (PARITY_MODE == 2) ? ~(^shift_q) : (^shift_q);

    // Receiver next state. Data bits shift in from the top so the first
    // (LSB) bit ends up in bit 0 after WORD_PART samples.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        par_bad_d  = par_bad_q;
        accept_d   = 1'b0;
        set_frame  = 1'b0;
        set_parity = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (prev_q && !sync2_q) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end
            end
            ST_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d     = '0;
                    bit_d     = '0;
                    par_bad_d = 1'b0;
                    state_d   = sync2_q ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[WORD_PART-1:1]};
                    if (bit_q == LAST_BIT) begin
                        state_d = (PARITY_MODE != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_PARITY: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d     = '0;
                    par_bad_d = (sync2_q != exp_parity);
                    state_d   = ST_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (!sync2_q) begin
                        set_frame = 1'b1;
                        state_d   = ST_WAIT_HIGH;
                    end else if (par_bad_q) begin
                        set_parity = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        accept_d = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_HIGH: begin
                if (sync2_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Packer. shift_q still holds the accepted character while accept_q is
    // high because no new frame can reach DATA that quickly.
    always_comb begin
        k_d          = k_q;
        word_d       = word_q;
        push_d       = 1'b0;
        push_word_d  = push_word_q;
        push_parts_d = push_parts_q;
        merged       = word_q;
        for (int i = 0; i < NPARTS; i++) begin
            if (k_q == PW'(i)) begin
                merged[i*WORD_PART +: WORD_PART] = shift_q;
            end
        end
        if (accept_q) begin
            if (shift_q == DELIM_C) begin
                if (k_q != '0) begin
                    push_d       = 1'b1;
                    push_word_d  = word_q;
                    push_parts_d = k_q;
                    word_d       = '0;
                    k_d          = '0;
                end
            end else if (k_q == LAST_PART) begin
                push_d       = 1'b1;
                push_word_d  = merged;
                push_parts_d = ALL_PARTS;
                word_d       = '0;
                k_d          = '0;
            end else begin
                word_d = merged;
                k_d    = k_q + 1'b1;
            end
        end
    end

    // FIFO control. A pop frees the head slot in the same cycle, so a push
    // at full only drops the word when no pop accompanies it.
    always_comb begin
        do_pop       = read_req && !empty_q;
        push_blocked = push_q && full_q && !do_pop;
        do_write     = push_q && !push_blocked;
        wr_ptr_d     = do_write ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d     = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d      = count_q;
        if (do_write && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_write && do_pop) begin
            count_d = count_q - 1'b1;
        end
        data_out_d   = do_pop ? mem_q[rd_ptr_q] : data_out_q;
        parts_d      = do_pop ? mem_parts_q[rd_ptr_q] : parts_q;
        full_d       = (count_d == MEM_FULL);
        empty_d      = (count_d == '0);
        frame_err_d  = set_frame | (frame_err_q & ~clear_err);
        parity_err_d = set_parity | (parity_err_q & ~clear_err);
        overflow_d   = push_blocked | (overflow_q & ~clear_err);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            prev_q       <= 1'b1;
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            par_bad_q    <= 1'b0;
            accept_q     <= 1'b0;
            k_q          <= '0;
            word_q       <= '0;
            push_q       <= 1'b0;
            push_word_q  <= '0;
            push_parts_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            data_out_q   <= '0;
            parts_q      <= '0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            sync1_q      <= sig;
            sync2_q      <= sync1_q;
            prev_q       <= sync2_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            par_bad_q    <= par_bad_d;
            accept_q     <= accept_d;
            k_q          <= k_d;
            word_q       <= word_d;
            push_q       <= push_d;
            push_word_q  <= push_word_d;
            push_parts_q <= push_parts_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            data_out_q   <= data_out_d;
            parts_q      <= parts_d;
            full_q       <= full_d;
            empty_q      <= empty_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overflow_q   <= overflow_d;
        end
    end

    // Storage array has no reset; only slots behind the write pointer are read.
    always_ff @(posedge clock) begin
        if (reset && do_write) begin
            mem_q[wr_ptr_q]       <= push_word_q;
            mem_parts_q[wr_ptr_q] <= push_parts_q;
        end
    end

    assign data_out   = data_out_q;
    assign parts      = parts_q;
    assign full       = full_q;
    assign empty      = empty_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_uart_word_packer.sv
`timescale 1ns/1ps
// Testbench for uart_word_packer. Four instances share clock and reset:
//   0: 8N1, 16 clocks per bit        (packing, delimiters, framing, reset)
//   1: even parity, 16 clocks per bit
//   2: 4-word FIFO, 16 clocks per bit (full / overflow / push+pop at full)
//   3: default 868 clocks per bit     (start-bit glitch rejection)
// Expected words go into a queue when stimulus is issued; a monitor pops
// and compares whenever an instance performs a pop.
module tb_uart_word_packer;

    logic        clock = 1'b0;
    logic        reset;
    logic        sig_line [4];
    logic        rd       [4];
    logic        clr      [4];
    logic [31:0] dout     [4];
    logic [2:0]  prt      [4];
    logic        emp [4], ful [4], ferr [4], perr [4], ovf [4];
    logic        popped   [4];

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          inst;
        logic [31:0] data;
        logic [2:0]  parts;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    always #5 clock = ~clock;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        uart_word_packer #(
            .WORD_SIZE   (32),
            .WORD_PART   (8),
            .MEM_SIZE    (g == 2 ? 4 : 64),
            .CLKS_PER_BIT(g == 3 ? 868 : 16),
            .PARITY_MODE (g == 1 ? 1 : 0),
            .DELIM       (9)
        ) dut (
            .clock     (clock),
            .reset     (reset),
            .sig       (sig_line[g]),
            .read_req  (rd[g]),
            .clear_err (clr[g]),
            .data_out  (dout[g]),
            .parts     (prt[g]),
            .full      (ful[g]),
            .empty     (emp[g]),
            .frame_err (ferr[g]),
            .parity_err(perr[g]),
            .overflow  (ovf[g])
        );
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // One serial frame: start, 8 data bits LSB first, optional parity bit
    // (par < 0 means none), stop bit of value stop_v, then a short idle gap.
    task automatic applyStimulus(input int inst, input logic [7:0] ch, input int par, input logic stop_v);
        int cpb;
        cpb = (inst == 3) ? 868 : 16;
        @(negedge clock);
        sig_line[inst] = 1'b0;
        repeat (cpb) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            sig_line[inst] = ch[i];
            repeat (cpb) @(negedge clock);
        end
        if (par >= 0) begin
            sig_line[inst] = par[0];
            repeat (cpb) @(negedge clock);
        end
        sig_line[inst] = stop_v;
        repeat (cpb) @(negedge clock);
        sig_line[inst] = 1'b1;
        repeat (4) @(negedge clock);
    endtask

    task automatic sendText(input int inst, input string s);
        for (int i = 0; i < s.len(); i++) begin
            applyStimulus(inst, s[i], -1, 1'b1);
        end
    endtask

    task automatic expectWord(input int inst, input logic [31:0] data, input logic [2:0] parts);
        exp_t e;
        e.inst  = inst;
        e.data  = data;
        e.parts = parts;
        exp_q.push_back(e);
    endtask

    task automatic popWord(input int inst);
        @(negedge clock);
        rd[inst] = 1'b1;
        @(negedge clock);
        rd[inst] = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic pulseClear(input int inst);
        @(negedge clock);
        clr[inst] = 1'b1;
        @(negedge clock);
        clr[inst] = 1'b0;
        @(negedge clock);
    endtask

    task automatic checkIdle(input int inst, input string tag);
        checkOutput({tag, "_data_out"}, dout[inst], 32'h0);
        checkOutput({tag, "_parts"}, 32'(prt[inst]), 32'h0);
        checkOutput({tag, "_full"}, 32'(ful[inst]), 32'h0);
        checkOutput({tag, "_empty"}, 32'(emp[inst]), 32'h1);
        checkOutput({tag, "_frame_err"}, 32'(ferr[inst]), 32'h0);
        checkOutput({tag, "_parity_err"}, 32'(perr[inst]), 32'h0);
        checkOutput({tag, "_overflow"}, 32'(ovf[inst]), 32'h0);
    endtask

    // A pop happens on an edge where read_req is high and empty is low.
    always @(posedge clock) begin
        for (int i = 0; i < 4; i++) begin
            popped[i] <= reset && rd[i] && !emp[i];
        end
    end

    always @(negedge clock) begin
        for (int i = 0; i < 4; i++) begin
            if (popped[i]) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_pop inst %0d got %h parts %0d expected no word", i, dout[i], prt[i]);
                end else begin
                    mon_e = exp_q.pop_front();
                    checkOutput($sformatf("pop_inst%0d_owner", i), 32'(i), 32'(mon_e.inst));
                    checkOutput($sformatf("pop_inst%0d_data", i), dout[i], mon_e.data);
                    checkOutput($sformatf("pop_inst%0d_parts", i), 32'(prt[i]), 32'(mon_e.parts));
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sig_line[i] = 1'b1;
            rd[i]       = 1'b0;
            clr[i]      = 1'b0;
        end
        repeat (5) @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checkIdle(0, "reset");

        // "hello\tworld\t"
        $display("[TB] hello/world packing");
        sendText(0, "hello\tworld\t");
        expectWord(0, 32'h6C6C6568, 3'd4);
        expectWord(0, 32'h0000006F, 3'd1);
        expectWord(0, 32'h6C726F77, 3'd4);
        expectWord(0, 32'h00000064, 3'd1);
        repeat (4) popWord(0);
        checkOutput("hello_empty_after", 32'(emp[0]), 32'h1);
        checkOutput("hello_frame_err", 32'(ferr[0]), 32'h0);
        checkOutput("hello_parity_err", 32'(perr[0]), 32'h0);
        checkOutput("hello_overflow", 32'(ovf[0]), 32'h0);

        // Leading delimiters produce nothing
        $display("[TB] leading delimiters");
        sendText(0, "\t\tab\t");
        expectWord(0, 32'h00006261, 3'd2);
        popWord(0);
        checkOutput("delim_empty_after", 32'(emp[0]), 32'h1);

        // Stop bit low, then 'A'
        $display("[TB] framing error");
        applyStimulus(0, 8'h55, -1, 1'b0);
        checkOutput("frame_err_set", 32'(ferr[0]), 32'h1);
        applyStimulus(0, 8'h41, -1, 1'b1);
        checkOutput("frame_err_sticky", 32'(ferr[0]), 32'h1);
        checkOutput("frame_no_push", 32'(emp[0]), 32'h1);
        pulseClear(0);
        checkOutput("frame_err_cleared", 32'(ferr[0]), 32'h0);
        sendText(0, "\t");
        expectWord(0, 32'h00000041, 3'd1);
        popWord(0);

        // Even parity: 0x03 needs parity bit 0
        $display("[TB] parity");
        applyStimulus(1, 8'h03, 1, 1'b1);
        checkOutput("parity_err_set", 32'(perr[1]), 32'h1);
        checkOutput("parity_dropped", 32'(emp[1]), 32'h1);
        applyStimulus(1, 8'h03, 0, 1'b1);
        applyStimulus(1, 8'h09, 0, 1'b1);
        expectWord(1, 32'h00000003, 3'd1);
        popWord(1);
        checkOutput("parity_err_sticky", 32'(perr[1]), 32'h1);
        checkOutput("parity_no_frame_err", 32'(ferr[1]), 32'h0);

        // 4-word FIFO
        $display("[TB] fifo full and overflow");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(2, 8'(8'h41 + i), -1, 1'b1);
        end
        checkOutput("full_after_16", 32'(ful[2]), 32'h1);
        checkOutput("no_overflow_yet", 32'(ovf[2]), 32'h0);
        for (int i = 16; i < 20; i++) begin
            applyStimulus(2, 8'(8'h41 + i), -1, 1'b1);
        end
        checkOutput("overflow_set", 32'(ovf[2]), 32'h1);
        checkOutput("full_still", 32'(ful[2]), 32'h1);
        expectWord(2, 32'h44434241, 3'd4);
        popWord(2);
        checkOutput("not_full_after_pop", 32'(ful[2]), 32'h0);
        sendText(2, "abcd");
        checkOutput("full_again", 32'(ful[2]), 32'h1);
        pulseClear(2);
        checkOutput("overflow_cleared", 32'(ovf[2]), 32'h0);
        sendText(2, "efg");
        expectWord(2, 32'h48474645, 3'd4);
        // The push of "efgh" lands 157 cycles after the start-bit negedge;
        // the pop is lined up on that same edge.
        fork
            applyStimulus(2, 8'h68, -1, 1'b1);
            begin
                @(negedge clock);
                repeat (156) @(negedge clock);
                rd[2] = 1'b1;
                @(negedge clock);
                rd[2] = 1'b0;
                checkOutput("push_pop_full_same_edge", 32'(ful[2]), 32'h1);
                @(negedge clock);
                checkOutput("push_pop_full_next", 32'(ful[2]), 32'h1);
            end
        join
        checkOutput("push_pop_no_overflow", 32'(ovf[2]), 32'h0);
        expectWord(2, 32'h4C4B4A49, 3'd4);
        expectWord(2, 32'h504F4E4D, 3'd4);
        expectWord(2, 32'h64636261, 3'd4);
        expectWord(2, 32'h68676665, 3'd4);
        repeat (4) popWord(2);
        checkOutput("fifo_drained", 32'(emp[2]), 32'h1);

        // 300-cycle low glitch at 868 clocks per bit
        $display("[TB] glitch rejection");
        @(negedge clock);
        sig_line[3] = 1'b0;
        repeat (300) @(negedge clock);
        sig_line[3] = 1'b1;
        repeat (600) @(negedge clock);
        checkOutput("glitch_empty", 32'(emp[3]), 32'h1);
        checkOutput("glitch_no_frame_err", 32'(ferr[3]), 32'h0);
        sendText(3, "a\t");
        expectWord(3, 32'h00000061, 3'd1);
        popWord(3);
        checkOutput("glitch_drained", 32'(emp[3]), 32'h1);

        // Reset in the middle of a DATA phase with a partial word pending
        $display("[TB] reset mid-frame");
        sendText(0, "x");
        @(negedge clock);
        sig_line[0] = 1'b0;
        repeat (16 + 3 * 16 + 5) @(negedge clock);
        reset       = 1'b0;
        sig_line[0] = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checkIdle(0, "midreset");
        sendText(0, "ab\t");
        expectWord(0, 32'h00006261, 3'd2);
        popWord(0);
        checkOutput("midreset_drained", 32'(emp[0]), 32'h1);

        repeat (4) @(negedge clock);
        checkOutput("scoreboard_leftover", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
